// File: rtl/pos_ring_inject_arbiter.sv
// Injection-port arbiter for the position input ring node: fixed-priority local stream,
// starvation-bounded remote stream, and a per-iteration FSM that reports drain completion.
module pos_ring_inject_arbiter #(
    parameter int PKT_W        = 80,
    parameter int GCID_W       = 9,
    parameter int LIFE_W       = 5,
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_iter_start,
    input  logic              i_local_done,
    input  logic              i_remote_last,
    input  logic              i_local_valid,
    input  logic [PKT_W-1:0]  i_local_pkt,
    input  logic [GCID_W-1:0] i_local_gcid,
    input  logic [LIFE_W-1:0] i_local_life,
    output logic              o_local_ready,
    input  logic              i_remote_valid,
    input  logic [PKT_W-1:0]  i_remote_pkt,
    input  logic [GCID_W-1:0] i_remote_gcid,
    input  logic [LIFE_W-1:0] i_remote_life,
    output logic              o_remote_ready,
    input  logic              i_ring_stall,
    output logic              o_ring_valid,
    output logic [PKT_W-1:0]  o_ring_pkt,
    output logic [GCID_W-1:0] o_ring_gcid,
    output logic [LIFE_W-1:0] o_ring_life,
    output logic              o_ring_src,
    output logic [CNT_W-1:0]  o_local_cnt,
    output logic [CNT_W-1:0]  o_remote_cnt,
    output logic              o_iter_done
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [3:0] LIMIT_C = 4'(STARVE_LIMIT);

    state_t     state_r;
    state_t     state_s;
    logic       latch_r;
    logic       latch_s;
    logic [3:0] wait_r;
    logic       can_load_s;
    logic       grant_local_s;
    logic       grant_remote_s;

    // Grant selection: a starved remote beats local, otherwise local has priority.
    always_comb begin
        can_load_s     = ~o_ring_valid | ~i_ring_stall;
        grant_local_s  = 1'b0;
        grant_remote_s = 1'b0;
        if (((state_r == RUN) || (state_r == DRAIN)) && can_load_s) begin
            if ((wait_r == LIMIT_C) && i_remote_valid) begin
                grant_remote_s = 1'b1;
            end else if (i_local_valid) begin
                grant_local_s = 1'b1;
            end else if (i_remote_valid) begin
                grant_remote_s = 1'b1;
            end else begin
                grant_local_s  = 1'b0;
                grant_remote_s = 1'b0;
            end
        end else begin
            grant_local_s  = 1'b0;
            grant_remote_s = 1'b0;
        end
    end

    assign o_local_ready  = grant_local_s;
    assign o_remote_ready = grant_remote_s;

    // Iteration FSM next-state and remote_last latch.
    always_comb begin
        state_s = state_r;
        latch_s = latch_r;
        case (state_r)
            IDLE: begin
                if (i_iter_start) begin
                    state_s = RUN;
                    latch_s = 1'b0;
                end else begin
                    state_s = IDLE;
                end
            end
            RUN: begin
                if (i_remote_last) begin
                    latch_s = 1'b1;
                end else begin
                    latch_s = latch_r;
                end
                if (latch_r && i_local_done) begin
                    state_s = DRAIN;
                end else begin
                    state_s = RUN;
                end
            end
            DRAIN: begin
                if (~i_local_valid & ~i_remote_valid & ~o_ring_valid) begin
                    state_s = DONE;
                end else begin
                    state_s = DRAIN;
                end
            end
            DONE:    state_s = IDLE;
            default: state_s = IDLE;
        endcase
    end

    // FSM state, latch and completion pulse.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_r     <= IDLE;
            latch_r     <= 1'b0;
            o_iter_done <= 1'b0;
        end else begin
            state_r     <= state_s;
            latch_r     <= latch_s;
            o_iter_done <= (state_r == DONE);
        end
    end

    // Output register: loads on grant, empties when consumed, holds while stalled.
    always_ff @(posedge clk) begin
        if (!rst) begin
            o_ring_valid <= 1'b0;
            o_ring_pkt   <= '0;
            o_ring_gcid  <= '0;
            o_ring_life  <= '0;
            o_ring_src   <= 1'b0;
        end else if (grant_local_s) begin
            o_ring_valid <= 1'b1;
            o_ring_pkt   <= i_local_pkt;
            o_ring_gcid  <= i_local_gcid;
            o_ring_life  <= i_local_life;
            o_ring_src   <= 1'b0;
        end else if (grant_remote_s) begin
            o_ring_valid <= 1'b1;
            o_ring_pkt   <= i_remote_pkt;
            o_ring_gcid  <= i_remote_gcid;
            o_ring_life  <= i_remote_life;
            o_ring_src   <= 1'b1;
        end else if (o_ring_valid && !i_ring_stall) begin
            o_ring_valid <= 1'b0;
        end else begin
            o_ring_valid <= o_ring_valid;
        end
    end

    // Starvation counter and per-iteration injection counters.
    always_ff @(posedge clk) begin
        if (!rst) begin
            wait_r       <= 4'd0;
            o_local_cnt  <= '0;
            o_remote_cnt <= '0;
        end else begin
            if (i_remote_valid && !grant_remote_s) begin
                wait_r <= (wait_r == LIMIT_C) ? wait_r : wait_r + 4'd1;
            end else begin
                wait_r <= 4'd0;
            end
            if ((state_r == IDLE) && i_iter_start) begin
                o_local_cnt  <= '0;
                o_remote_cnt <= '0;
            end else begin
                if (grant_local_s) begin
                    o_local_cnt <= o_local_cnt + CNT_W'(1);
                end else begin
                    o_local_cnt <= o_local_cnt;
                end
                if (grant_remote_s) begin
                    o_remote_cnt <= o_remote_cnt + CNT_W'(1);
                end else begin
                    o_remote_cnt <= o_remote_cnt;
                end
            end
        end
    end

endmodule

// File: doc/pos_ring_inject_arbiter.md
Name: pos_ring_inject_arbiter

Overview:
- Shares the single injection port of the position input ring node between two requesters: the local source stream and the remote position stream (decoded from the remote input FIFO by the remote-to-ring controller).
- Local traffic has fixed priority. A wait counter bounds remote starvation.
- A per-iteration FSM gates injection and detects drain completion, so the force-evaluation phase can start only after all local and remote positions have entered the ring.

Parameters:
- PKT_W, 80, width of offset packet (offset x/y/z, element, particle id)
- GCID_W, 9, width of packed 3-D global cell id
- LIFE_W, 5, width of lifetime field
- STARVE_LIMIT, 4, consecutive losing cycles before remote is force-granted (1..15)
- CNT_W, 16, width of per-iteration injection counters

Ports:
- clk  in  1  clock
- rst  in  1  synchronous reset, active-low
- i_iter_start  in  1  one-cycle pulse; opens an iteration
- i_local_done  in  1  level; local source has issued its final packet
- i_remote_last  in  1  one-cycle pulse; remote controller's last transfer of the iteration
- i_local_valid  in  1  local request
- i_local_pkt  in  PKT_W  local offset packet
- i_local_gcid  in  GCID_W  local gcid
- i_local_life  in  LIFE_W  local lifetime
- o_local_ready  out  1  local packet accepted this cycle
- i_remote_valid  in  1  remote request
- i_remote_pkt  in  PKT_W  remote offset packet
- i_remote_gcid  in  GCID_W  remote gcid
- i_remote_life  in  LIFE_W  remote lifetime
- o_remote_ready  out  1  remote packet accepted (acts as remote ack)
- i_ring_stall  in  1  ring node cannot take a packet this cycle
- o_ring_valid  out  1  output register holds a packet
- o_ring_pkt  out  PKT_W  packet to ring
- o_ring_gcid  out  GCID_W  gcid to ring
- o_ring_life  out  LIFE_W  lifetime to ring
- o_ring_src  out  1  0 = local, 1 = remote
- o_local_cnt  out  CNT_W  local packets injected this iteration
- o_remote_cnt  out  CNT_W  remote packets injected this iteration
- o_iter_done  out  1  one-cycle pulse when the iteration is fully drained

Behaviour:
- Reset (rst == 0 at a clk edge):
  - All outputs are 0.
  - FSM goes to IDLE.
  - Wait counter and remote_last latch are cleared.
- Output stage:
  - Single register. The packet held in it is consumed on a cycle where o_ring_valid = 1 and i_ring_stall = 0.
  - can_load = ~o_ring_valid | ~i_ring_stall.
  - Fields stay stable while stalled.
- Grant (combinational, only in RUN or DRAIN, and only when can_load = 1):
  - If wait_cnt == STARVE_LIMIT and i_remote_valid: grant remote.
  - Otherwise, if i_local_valid: grant local.
  - Otherwise, if i_remote_valid: grant remote.
  - o_local_ready / o_remote_ready = the respective grant. At most one is high per cycle.
  - A grant loads the output register on the same edge. Latency is 1 cycle from accepted request to o_ring_valid.
- Wait counter:
  - Increments when i_remote_valid = 1 and remote is not granted, saturating at STARVE_LIMIT.
  - Clears on remote grant or when i_remote_valid = 0.
- Counters:
  - o_local_cnt / o_remote_cnt increment on the respective grant and wrap modulo 2^CNT_W.
  - Both clear on i_iter_start.
- FSM:
  - IDLE: no grants; both ready signals are 0. On i_iter_start go to RUN and clear the counters and the latch.
  - RUN: arbitrate. i_remote_last sets the latch (a pulse is never lost, including on the same cycle as a remote grant). When latch = 1 and i_local_done = 1, go to DRAIN.
  - DRAIN: keep arbitrating, which flushes residual requests. When ~i_local_valid & ~i_remote_valid & ~o_ring_valid, go to DONE.
  - DONE: assert o_iter_done for exactly one cycle, then go to IDLE.
- i_iter_start outside IDLE is ignored.
- i_remote_last outside RUN is ignored; the latch is held in DRAIN.
- Reset mid-iteration: any packet in the output register is discarded, and no o_iter_done is produced.

Test Plan:
- Reset and IDLE gating: hold rst = 0 for 5 cycles, then release and assert i_local_valid with no i_iter_start → o_local_ready = 0, o_ring_valid = 0, counters = 0.
- Basic injection and latency:
  - Stimulus: pulse i_iter_start; one local packet with pkt = 0x1_000003_000002_000001, gcid = 0, life = 4.
  - Response: o_ring_valid rises 1 cycle later with identical fields, o_ring_src = 0, o_local_cnt = 1.
- Starvation bound:
  - Stimulus: STARVE_LIMIT = 4; local and remote both valid continuously for 12 cycles.
  - Response: grant pattern L,L,L,L,R repeating; o_remote_cnt = 2 and o_local_cnt = 10 after 12 grants.
- Ring stall hold:
  - Stimulus: i_ring_stall = 1 for 3 cycles with a packet loaded.
  - Response: fields stable, both ready signals = 0. On stall release the packet is consumed and the next grant occurs the same cycle.
- Iteration completion:
  - Stimulus: i_remote_last pulses while i_local_done = 0; i_local_done rises 6 cycles later; inputs then drain.
  - Response: o_iter_done is a single-cycle pulse exactly 2 cycles after the output register empties (DRAIN→DONE, DONE pulse); FSM returns to IDLE.
- Reset mid-operation: assert rst = 0 while in DRAIN with o_ring_valid = 1 → next cycle all outputs 0, FSM in IDLE, no o_iter_done.
